// File: rtl/dm_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dm_arb_pkg
// Brief    : Shared state encoding, requester ids and defaults for dm_arbiter.
// Revision : 1.0
// ============================================================================
package dm_arb_pkg;

    localparam int   c_WAIT_DEFAULT = 1;
    localparam int   c_CNT_W        = 4;

    localparam logic c_ID_CPU = 1'b0;
    localparam logic c_ID_DMA = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    function automatic logic is_aligned(input logic [1:0] addr_lsb);
        return addr_lsb == 2'b00;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter2
// Brief    : Two-way round-robin grant selection (combinational, one-hot).
// Revision : 1.0
// ============================================================================
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic [1:0] last_gnt,
    output logic [1:0] grant
);

    // last_gnt is the one-hot grant of the previous winner; 2'b00 after reset
    // so requester 0 wins the first tie.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_gnt == 2'b01) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dm_arbiter
// Brief    : CPU/DMA data-memory arbiter with wait states and alignment check.
// Revision : 1.0
// ============================================================================
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int WAIT = c_WAIT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic [31:0] pc0,
    input  logic [31:0] pc1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    output logic [31:0] mem_pc,
    input  logic [31:0] mem_rd
);

    localparam logic [c_CNT_W-1:0] c_WAIT_LOAD = (WAIT > 0) ? c_CNT_W'(WAIT - 1) : '0;

    state_t             r_state;
    state_t             w_next_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_we;
    logic               r_id;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [31:0]        r_pc;
    logic [31:0]        r_rdata;
    logic               r_err;
    logic [1:0]         r_last_gnt;
    logic [1:0]         w_grant;
    logic               w_accept;
    logic               w_aligned;

    rr_arbiter2 u_rr (
        .req      ({req1, req0}),
        .last_gnt (r_last_gnt),
        .grant    (w_grant)
    );

    assign w_accept  = (r_state == ST_IDLE) && (w_grant != 2'b00);
    assign w_aligned = is_aligned(r_addr[1:0]);

    assign mem_a  = r_addr;
    assign mem_wd = r_wdata;
    assign mem_pc = r_pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_we       <= 1'b0;
            r_id       <= c_ID_CPU;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_pc       <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_last_gnt <= 2'b00;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_id       <= w_grant[1] ? c_ID_DMA : c_ID_CPU;
                        r_we       <= w_grant[1] ? we1    : we0;
                        r_addr     <= w_grant[1] ? addr1  : addr0;
                        r_wdata    <= w_grant[1] ? wdata1 : wdata0;
                        r_pc       <= w_grant[1] ? pc1    : pc0;
                        r_cnt      <= c_WAIT_LOAD;
                        r_last_gnt <= w_grant;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_ACCESS: begin
                    // Stores and misaligned accesses return zero data.
                    r_rdata <= (!r_we && w_aligned) ? mem_rd : '0;
                    r_err   <= !w_aligned;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next_state = r_state;
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        mem_we       = 1'b0;
        done0        = 1'b0;
        done1        = 1'b0;
        rdata0       = '0;
        rdata1       = '0;
        err0         = 1'b0;
        err1         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                gnt0 = w_grant[0];
                gnt1 = w_grant[1];
                if (w_accept) begin
                    w_next_state = (WAIT > 0) ? ST_WAIT : ST_ACCESS;
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_next_state = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_we       = r_we && w_aligned;
                w_next_state = ST_RESP;
            end
            ST_RESP: begin
                if (r_id == c_ID_DMA) begin
                    done1  = 1'b1;
                    rdata1 = r_rdata;
                    err1   = r_err;
                end else begin
                    done0  = 1'b1;
                    rdata0 = r_rdata;
                    err0   = r_err;
                end
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_arbiter
// Brief    : Self-checking bench for dm_arbiter (vectors, corner cases, random).
// Revision : 1.0
// ============================================================================
module tb_dm_arbiter;

    localparam int W = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1, pc0, pc1;
    logic        gnt0, gnt1, done0, done1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] mem_a, mem_wd, mem_pc, mem_rd;
    logic        mem_we;

    logic        req0_z, req1_z, we0_z, we1_z;
    logic [31:0] addr0_z, addr1_z, wdata0_z, wdata1_z, pc0_z, pc1_z;
    logic        gnt0_z, gnt1_z, done0_z, done1_z, err0_z, err1_z;
    logic [31:0] rdata0_z, rdata1_z;
    logic [31:0] mem_a_z, mem_wd_z, mem_pc_z, mem_rd_z;
    logic        mem_we_z;

    always #5 clk = ~clk;

    dm_arbiter #(.WAIT(W)) u_dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .pc0(pc0), .pc1(pc1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
        .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_pc(mem_pc),
        .mem_rd(mem_rd)
    );

    dm_arbiter #(.WAIT(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .req0(req0_z), .req1(req1_z), .we0(we0_z), .we1(we1_z),
        .addr0(addr0_z), .addr1(addr1_z), .wdata0(wdata0_z), .wdata1(wdata1_z),
        .pc0(pc0_z), .pc1(pc1_z),
        .gnt0(gnt0_z), .gnt1(gnt1_z), .done0(done0_z), .done1(done1_z),
        .rdata0(rdata0_z), .rdata1(rdata1_z), .err0(err0_z), .err1(err1_z),
        .mem_a(mem_a_z), .mem_wd(mem_wd_z), .mem_we(mem_we_z), .mem_pc(mem_pc_z),
        .mem_rd(mem_rd_z)
    );

    // Memory behind the main instance: 16 words, addressed by mem_a[5:2].
    logic [31:0] tb_mem [16];
    logic        mem_init;

    function automatic logic [31:0] init_val(input int i);
        if (i == 4) return 32'hCAFE_F00D;
        return 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) tb_mem[i] <= init_val(i);
        end else if (mem_we) begin
            tb_mem[mem_a[5:2]] <= mem_wd;
        end
    end

    assign mem_rd = tb_mem[mem_a[5:2]];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        mem_init = 1'b1;
        req0 = 1'b0; req1 = 1'b0; req0_z = 1'b0; req1_z = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset    = 1'b0;
        mem_init = 1'b0;
    endtask

    typedef struct {
        logic        id;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    // Single isolated access; the bus must be idle on entry (posedge+1).
    task automatic run_vec(input vec_t v, input int n);
        bit seen;
        seen = 1'b0;
        if (v.id) begin
            req1 = 1'b1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata; pc1 = v.pc;
        end else begin
            req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata; pc0 = v.pc;
        end
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = v.id ? gnt1 : gnt0;
        end
        chk($sformatf("vec%0d_gnt", n), 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        req0 = 1'b0;
        req1 = 1'b0;
        if (!seen) return;
        for (int k = 1; k <= W + 2; k++) begin
            @(negedge clk);
            if (k == W + 1) begin
                chk($sformatf("vec%0d_mem_we", n), 32'(mem_we),
                    32'(v.we && (v.addr[1:0] == 2'b00)));
                chk($sformatf("vec%0d_mem_a", n), mem_a, v.addr);
                chk($sformatf("vec%0d_mem_wd", n), mem_wd, v.wdata);
                chk($sformatf("vec%0d_mem_pc", n), mem_pc, v.pc);
            end else begin
                chk($sformatf("vec%0d_mem_we_idle", n), 32'(mem_we), 32'd0);
            end
            if (k == W + 2) begin
                chk($sformatf("vec%0d_done", n), 32'({done1, done0}), v.id ? 32'd2 : 32'd1);
                chk($sformatf("vec%0d_rdata", n), v.id ? rdata1 : rdata0, v.exp_rd);
                chk($sformatf("vec%0d_err", n), 32'(v.id ? err1 : err0), 32'(v.exp_err));
                chk($sformatf("vec%0d_other_port", n),
                    (v.id ? rdata0 : rdata1) | 32'(v.id ? err0 : err1), 32'd0);
            end else begin
                chk($sformatf("vec%0d_quiet", n),
                    32'({done1, done0, err1, err0}) | rdata0 | rdata1, 32'd0);
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = 32'($urandom_range(63, 0));
        if ($urandom_range(3, 0) != 0) a[1:0] = 2'b00;
        return a;
    endfunction

    // Reference model state for the random phase
    logic [31:0] ref_mem [16];
    int          busy_until, last_g, win, t_start, t_id, n_gnt, last_c;
    bit          have_txn;
    logic        t_we;
    logic [31:0] t_addr, t_wdata, t_pc, exp_rd;
    logic [1:0]  exp_g, exp_done, acc;
    logic        exp_we, exp_err, seen_g;

    initial begin
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; pc0 = 0; pc1 = 0;
        req0_z = 0; req1_z = 0; we0_z = 0; we1_z = 0;
        addr0_z = 0; addr1_z = 0; wdata0_z = 0; wdata1_z = 0; pc0_z = 0; pc1_z = 0;
        mem_rd_z = 32'd0;
        mem_init = 1'b1;
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("reset_flags", 32'({gnt0, gnt1, done0, done1, err0, err1, mem_we}), 32'd0);
        chk("reset_rdata", rdata0 | rdata1, 32'd0);
        chk("reset_mem_bus", mem_a | mem_wd | mem_pc, 32'd0);
        do_reset();

        // Directed access vectors
        vecs[0] = '{1'b1, 1'b0, 32'h10, 32'h0,         32'h4000, 32'hCAFE_F00D, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 32'h10, 32'h1234_5678, 32'h3000, 32'h0,         1'b0};
        vecs[2] = '{1'b0, 1'b0, 32'h10, 32'h0,         32'h3004, 32'h1234_5678, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 32'h13, 32'hDEAD_BEEF, 32'h3008, 32'h0,         1'b1};
        vecs[4] = '{1'b1, 1'b0, 32'h13, 32'h0,         32'h4004, 32'h0,         1'b1};
        vecs[5] = '{1'b1, 1'b0, 32'h10, 32'h0,         32'h4008, 32'h1234_5678, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 32'h24, 32'h0BAD_CAFE, 32'h400C, 32'h0,         1'b0};
        vecs[7] = '{1'b0, 1'b0, 32'h24, 32'h0,         32'h300C, 32'h0BAD_CAFE, 1'b0};
        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Both requesters held high: grants alternate 0,1,0,1
        do_reset();
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h8; pc0 = 32'h3010;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'hC; pc1 = 32'h4010;
        n_gnt = 0;
        last_c = 0;
        for (int c = 0; c < 60 && n_gnt < 4; c++) begin
            @(negedge clk);
            if (done0 | done1) begin
                chk("rr_done_port", 32'({done1, done0}), ((n_gnt - 1) % 2 == 1) ? 32'd2 : 32'd1);
                chk("rr_rdata", done1 ? rdata1 : rdata0, done1 ? init_val(3) : init_val(2));
            end
            if (gnt0 | gnt1) begin
                chk("rr_order", 32'({gnt1, gnt0}), (n_gnt % 2 == 1) ? 32'd2 : 32'd1);
                if (n_gnt > 0) chk("rr_spacing", 32'(c - last_c), 32'(W + 3));
                last_c = c;
                n_gnt++;
            end
        end
        chk("rr_count", 32'(n_gnt), 32'd4);
        @(posedge clk);
        #1;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (W + 4) @(posedge clk);
        #1;

        // Reset in the middle of a WAIT-state store
        do_reset();
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; wdata0 = 32'h5555_AAAA; pc0 = 32'h3100;
        seen_g = 1'b0;
        for (int k = 0; k < 20 && !seen_g; k++) begin
            @(negedge clk);
            seen_g = gnt0;
        end
        chk("abort_gnt", 32'(seen_g), 32'd1);
        @(posedge clk);
        #1;
        req0 = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("abort_flags", 32'({gnt0, gnt1, done0, done1, err0, err1, mem_we}), 32'd0);
        chk("abort_bus", mem_a | mem_wd | mem_pc | rdata0 | rdata1, 32'd0);
        @(posedge clk);
        #3 reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("abort_quiet", 32'({mem_we, done1, done0}), 32'd0);
        end
        chk("abort_mem_intact", tb_mem[8], init_val(8));
        @(posedge clk);
        #1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h4;
        @(negedge clk);
        chk("abort_prio_reset", 32'({gnt1, gnt0}), 32'd1);
        @(posedge clk);
        #1;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (W + 4) @(posedge clk);
        #1;

        // Zero wait-state instance: mem_we at T+1, done at T+2, next grant T+3
        req0_z = 1'b1; we0_z = 1'b1; addr0_z = 32'h4; wdata0_z = 32'h7777_1111; pc0_z = 32'h3200;
        seen_g = 1'b0;
        for (int k = 0; k < 20 && !seen_g; k++) begin
            @(negedge clk);
            seen_g = gnt0_z;
        end
        chk("w0_gnt", 32'(seen_g), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("w0_t1", 32'({mem_we_z, done0_z, gnt0_z}), 32'b100);
        chk("w0_mem_a", mem_a_z, 32'h4);
        @(negedge clk);
        chk("w0_t2", 32'({mem_we_z, done0_z, gnt0_z, err0_z}), 32'b0100);
        @(negedge clk);
        chk("w0_t3_gnt", 32'(gnt0_z), 32'd1);
        @(posedge clk);
        #1;
        req0_z = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Random traffic against the reference model
        do_reset();
        for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
        busy_until = 0;
        last_g     = -1;
        have_txn   = 1'b0;
        t_start    = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            exp_g = 2'b00;
            acc   = 2'b00;
            if (c >= busy_until && (req0 || req1)) begin
                if (req0 && req1) win = (last_g == 0) ? 1 : 0;
                else              win = req1 ? 1 : 0;
                exp_g   = (win == 1) ? 2'b10 : 2'b01;
                t_id    = win;
                t_we    = (win == 1) ? we1 : we0;
                t_addr  = (win == 1) ? addr1 : addr0;
                t_wdata = (win == 1) ? wdata1 : wdata0;
                t_pc    = (win == 1) ? pc1 : pc0;
                t_start = c;
                busy_until = c + W + 3;
                last_g  = win;
                have_txn = 1'b1;
                acc     = exp_g;
            end
            chk("rand_gnt", 32'({gnt1, gnt0}), 32'(exp_g));
            exp_we   = 1'b0;
            exp_done = 2'b00;
            exp_rd   = 32'd0;
            exp_err  = 1'b0;
            if (have_txn && c == t_start + W + 1) begin
                exp_we = t_we && (t_addr[1:0] == 2'b00);
                chk("rand_mem_a", mem_a, t_addr);
                chk("rand_mem_wd", mem_wd, t_wdata);
                chk("rand_mem_pc", mem_pc, t_pc);
                if (exp_we) ref_mem[t_addr[5:2]] = t_wdata;
            end
            if (have_txn && c == t_start + W + 2) begin
                exp_done = (t_id == 1) ? 2'b10 : 2'b01;
                exp_err  = (t_addr[1:0] != 2'b00);
                exp_rd   = (!t_we && !exp_err) ? ref_mem[t_addr[5:2]] : 32'd0;
            end
            chk("rand_mem_we", 32'(mem_we), 32'(exp_we));
            chk("rand_done", 32'({done1, done0}), 32'(exp_done));
            chk("rand_rdata0", rdata0, exp_done[0] ? exp_rd : 32'd0);
            chk("rand_rdata1", rdata1, exp_done[1] ? exp_rd : 32'd0);
            chk("rand_err", 32'({err1, err0}),
                32'({exp_done[1] & exp_err, exp_done[0] & exp_err}));
            @(posedge clk);
            #1;
            if (acc[0]) req0 = 1'b0;
            if (acc[1]) req1 = 1'b0;
            if (!req0 && $urandom_range(1, 0) == 1) begin
                req0 = 1'b1; we0 = 1'($urandom_range(1, 0)); addr0 = rand_addr();
                wdata0 = $urandom; pc0 = $urandom;
            end
            if (!req1 && $urandom_range(1, 0) == 1) begin
                req1 = 1'b1; we1 = 1'($urandom_range(1, 0)); addr1 = rand_addr();
                wdata1 = $urandom; pc1 = $urandom;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (W + 4) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
